// File: rtl/retire_stage_pkg.sv
// ============================================================================
// Module   : retire_stage_pkg
// Purpose  : Shared retire-stage types: tags, ROB/free-list/AMT packets, FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

package retire_stage_pkg;

    localparam int XLEN   = `XLEN;
    localparam int PREG_W = 6;
    localparam int AREG_W = 5;

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] tag;
    } TAG;

    typedef struct packed {
        logic              retire_en;
        TAG                retire_t;
        TAG                retire_t_old;
        logic              halt;
        logic              wr_mem;
        logic [AREG_W-1:0] dest_reg_idx;
        logic [XLEN-1:0]   NPC;
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   rs2_value;
        logic              take_branch;
    } ROB_IR_PACKET;

    typedef struct packed {
        logic free_en;
        TAG   free_t;
    } IR_FL_PACKET;

    typedef struct packed {
        logic              write_en;
        logic [AREG_W-1:0] dest_reg_idx;
        TAG                t;
    } IR_AMT_PACKET;

    typedef enum logic [1:0] {
        RS_RUN        = 2'd0,
        RS_STORE_WAIT = 2'd1,
        RS_SQUASH     = 2'd2,
        RS_HALTED     = 2'd3
    } RETIRE_STATE;

    // Architectural register 0 is hardwired, so it never gets a map update.
    function automatic logic writes_amt(input TAG t, input logic [AREG_W-1:0] idx);
        return t.valid && (idx != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/retire_stage_if.sv
// ============================================================================
// Module   : retire_stage_if
// Purpose  : ROB head handshake and store-commit memory port of the retire stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface retire_stage_if
    import retire_stage_pkg::*;
#(
    parameter int XLEN_W = `XLEN
) ();

    ROB_IR_PACKET      rob_ir_packet;
    logic              ir_rob_ack;
    logic              mem_req;
    logic [XLEN_W-1:0] mem_addr;
    logic [XLEN_W-1:0] mem_data;
    logic              mem_gnt;

    modport master (
        input  rob_ir_packet,
        input  mem_gnt,
        output ir_rob_ack,
        output mem_req,
        output mem_addr,
        output mem_data
    );

    modport slave (
        output rob_ir_packet,
        output mem_gnt,
        input  ir_rob_ack,
        input  mem_req,
        input  mem_addr,
        input  mem_data
    );

endinterface

`default_nettype wire

// File: rtl/retire_store_port.sv
// ============================================================================
// Module   : retire_store_port
// Purpose  : Store-commit request register; holds req/addr/data until granted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module retire_store_port #(
    parameter int XLEN_W = `XLEN
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic [XLEN_W-1:0] addr,
    input  wire logic [XLEN_W-1:0] data,
    input  wire logic              gnt,
    output logic                   req,
    output logic [XLEN_W-1:0]      req_addr,
    output logic [XLEN_W-1:0]      req_data
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req      <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
        end else if (start) begin
            req      <= 1'b1;
            req_addr <= addr;
            req_data <= data;
        end else if (req && gnt) begin
            req <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/retire_stage.sv
// ============================================================================
// Module   : retire_stage
// Purpose  : In-order retire FSM (RUN/STORE_WAIT/SQUASH/HALTED). Optional
//            statistics counters are enabled by the RETIRE_STATS_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module retire_stage
    import retire_stage_pkg::*;
#(
    parameter int XLEN_W = `XLEN,
    parameter int STAT_W = 32
) (
    input  wire logic          clock,
    input  wire logic          reset,
    retire_stage_if.master     bus,
    output IR_FL_PACKET        ir_fl_packet,
    output IR_AMT_PACKET       ir_amt_packet,
    output logic               squash_en,
    output logic [XLEN_W-1:0]  squash_pc,
    output logic               halted
`ifdef RETIRE_STATS_EN
    ,
    output logic [STAT_W-1:0]  retired_cnt,
    output logic [STAT_W-1:0]  store_cnt
`endif
);

    RETIRE_STATE  state;
    ROB_IR_PACKET head;
    logic         ack;
    logic         store_start;
    logic         unused_npc;

    assign head        = bus.rob_ir_packet;
    assign unused_npc  = ^head.NPC;
    assign store_start = reset && (state == RS_RUN) && head.retire_en && head.wr_mem;

    // Ack is combinational so the ROB can pop the head in the same cycle.
    always_comb begin
        ack = 1'b0;
        if (reset) begin
            case (state)
                RS_RUN:        ack = head.retire_en && !head.wr_mem;
                RS_STORE_WAIT: ack = bus.mem_gnt;
                default:       ack = 1'b0;
            endcase
        end
    end

    assign bus.ir_rob_ack = ack;

    retire_store_port #(
        .XLEN_W (XLEN_W)
    ) u_store_port (
        .clock    (clock),
        .reset    (reset),
        .start    (store_start),
        .addr     (head.result),
        .data     (head.rs2_value),
        .gnt      (bus.mem_gnt),
        .req      (bus.mem_req),
        .req_addr (bus.mem_addr),
        .req_data (bus.mem_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= RS_RUN;
            ir_fl_packet  <= '0;
            ir_amt_packet <= '0;
            squash_en     <= 1'b0;
            squash_pc     <= '0;
            halted        <= 1'b0;
        end else begin
            ir_fl_packet.free_en       <= ack && head.retire_t_old.valid;
            ir_fl_packet.free_t        <= head.retire_t_old;
            ir_amt_packet.write_en     <= ack && writes_amt(head.retire_t, head.dest_reg_idx);
            ir_amt_packet.dest_reg_idx <= head.dest_reg_idx;
            ir_amt_packet.t            <= head.retire_t;
            squash_en                  <= 1'b0;

            if (ack) begin
                if (head.halt) begin
                    state  <= RS_HALTED;
                    halted <= 1'b1;
                end else if (head.take_branch) begin
                    state     <= RS_SQUASH;
                    squash_en <= 1'b1;
                    squash_pc <= head.result;
                end else begin
                    state <= RS_RUN;
                end
            end else begin
                case (state)
                    RS_RUN:        if (store_start) state <= RS_STORE_WAIT;
                    RS_STORE_WAIT: state <= RS_STORE_WAIT;
                    RS_SQUASH:     state <= RS_RUN;
                    RS_HALTED:     state <= RS_HALTED;
                    default:       state <= RS_RUN;
                endcase
            end
        end
    end

`ifdef RETIRE_STATS_EN
    // Both counters saturate rather than wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_cnt <= '0;
            store_cnt   <= '0;
        end else if (ack) begin
            if (~&retired_cnt) retired_cnt <= retired_cnt + STAT_W'(1);
            if ((state == RS_STORE_WAIT) && ~&store_cnt) store_cnt <= store_cnt + STAT_W'(1);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_retire_stage.sv
// ============================================================================
// Module   : tb_retire_stage
// Purpose  : Directed scoreboard bench for retire_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_retire_stage;
    import retire_stage_pkg::*;

    localparam int XW = `XLEN;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    IR_FL_PACKET   fl;
    IR_AMT_PACKET  amt;
    logic          squash_en;
    logic [XW-1:0] squash_pc;
    logic          halted;
`ifdef RETIRE_STATS_EN
    logic [31:0]   retired_cnt;
    logic [31:0]   store_cnt;
`endif

    retire_stage_if #(.XLEN_W(XW)) bus ();

    retire_stage #(
        .XLEN_W (XW),
        .STAT_W (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .ir_fl_packet  (fl),
        .ir_amt_packet (amt),
        .squash_en     (squash_en),
        .squash_pc     (squash_pc),
        .halted        (halted)
`ifdef RETIRE_STATS_EN
        ,
        .retired_cnt   (retired_cnt),
        .store_cnt     (store_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct { int c; TAG t; }                      fl_exp_t;
    typedef struct { int c; logic [4:0] d; TAG t; }       amt_exp_t;
    typedef struct { int c; logic [XW-1:0] pc; }          sq_exp_t;

    fl_exp_t  fl_q[$];
    amt_exp_t amt_q[$];
    sq_exp_t  sq_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int halt_cyc = 1 << 30;
    int n_acks   = 0;
    int n_stores = 0;
    logic          exp_req  = 1'b0;
    logic [XW-1:0] exp_addr = '0;
    logic [XW-1:0] exp_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic tv, input int t, input logic ov, input int to,
                         input int dest, input logic wr, input logic hl, input logic br,
                         input logic [XW-1:0] res, input logic [XW-1:0] rs2);
        bus.rob_ir_packet.retire_en    = en;
        bus.rob_ir_packet.retire_t     = '{valid: tv, tag: t[5:0]};
        bus.rob_ir_packet.retire_t_old = '{valid: ov, tag: to[5:0]};
        bus.rob_ir_packet.halt         = hl;
        bus.rob_ir_packet.wr_mem       = wr;
        bus.rob_ir_packet.dest_reg_idx = dest[4:0];
        bus.rob_ir_packet.NPC          = res + XW'(4);
        bus.rob_ir_packet.result       = res;
        bus.rob_ir_packet.rs2_value    = rs2;
        bus.rob_ir_packet.take_branch  = br;
    endtask

    task automatic alu(input int t, input int to, input int dest);
        drive(1'b1, 1'b1, t, 1'b1, to, dest, 1'b0, 1'b0, 1'b0, XW'(32'h1000 + t), '0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Record what the head being acked this cycle must produce next cycle.
    task automatic expect_retire();
        ROB_IR_PACKET h;
        h = bus.rob_ir_packet;
        if (h.retire_t_old.valid) fl_q.push_back('{c: cyc + 1, t: h.retire_t_old});
        if (h.retire_t.valid && h.dest_reg_idx != 0)
            amt_q.push_back('{c: cyc + 1, d: h.dest_reg_idx, t: h.retire_t});
        if (h.take_branch) sq_q.push_back('{c: cyc + 1, pc: h.result});
        if (h.halt) halt_cyc = cyc + 1;
        n_acks++;
        if (h.wr_mem) n_stores++;
    endtask

    task automatic tick(input logic exp_ack, input string tag);
        logic e;
        @(negedge clock);
        chk({tag, "_ack"}, 64'(bus.ir_rob_ack), 64'(exp_ack));
        if (exp_ack) expect_retire();
        e = (fl_q.size() > 0) && (fl_q[0].c == cyc);
        chk("free_en", 64'(fl.free_en), 64'(e));
        if (e) begin
            chk("free_t", 64'(fl.free_t), 64'(fl_q[0].t));
            void'(fl_q.pop_front());
        end
        e = (amt_q.size() > 0) && (amt_q[0].c == cyc);
        chk("amt_write_en", 64'(amt.write_en), 64'(e));
        if (e) begin
            chk("amt_dest", 64'(amt.dest_reg_idx), 64'(amt_q[0].d));
            chk("amt_t", 64'(amt.t), 64'(amt_q[0].t));
            void'(amt_q.pop_front());
        end
        e = (sq_q.size() > 0) && (sq_q[0].c == cyc);
        chk("squash_en", 64'(squash_en), 64'(e));
        if (e) begin
            chk("squash_pc", 64'(squash_pc), 64'(sq_q[0].pc));
            void'(sq_q.pop_front());
        end
        chk("halted", 64'(halted), 64'(cyc >= halt_cyc));
        chk("mem_req", 64'(bus.mem_req), 64'(exp_req));
        if (exp_req) begin
            chk("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
            chk("mem_data", 64'(bus.mem_data), 64'(exp_data));
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_gnt = 1'b0;
        alu(30, 31, 3);
        #1 reset = 1'b0;
        // A ready ALU head must not be acked while reset is held.
        @(negedge clock);
        chk("rst_ack", 64'(bus.ir_rob_ack), 64'd0);
        chk("rst_free_en", 64'(fl.free_en), 64'd0);
        chk("rst_write_en", 64'(amt.write_en), 64'd0);
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_data", 64'(bus.mem_data), 64'd0);
        chk("rst_squash_en", 64'(squash_en), 64'd0);
        chk("rst_squash_pc", 64'(squash_pc), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
`ifdef RETIRE_STATS_EN
        chk("rst_retired_cnt", 64'(retired_cnt), 64'd0);
        chk("rst_store_cnt", 64'(store_cnt), 64'd0);
`endif
        @(posedge clock);
        #1;
        idle();
        reset = 1'b1;
        cyc = 0;
        tick(1'b0, "idle");

        // Three back-to-back ALU heads.
        alu(5, 1, 4); tick(1'b1, "alu0");
        alu(6, 2, 5); tick(1'b1, "alu1");
        alu(7, 3, 6); tick(1'b1, "alu2");
        idle();       tick(1'b0, "alu_drain");

        // Destination x0: free list updated, AMT write suppressed.
        alu(8, 9, 0); tick(1'b1, "dest0");
        idle();       tick(1'b0, "dest0_drain");

        // Taken branch, then a squash cycle with no ack.
        drive(1'b1, 1'b1, 10, 1'b1, 11, 7, 1'b0, 1'b0, 1'b1, XW'(32'h40), '0);
        tick(1'b1, "branch");
        alu(12, 13, 8); tick(1'b0, "squash");
        tick(1'b1, "after_squash");
        idle();         tick(1'b0, "branch_drain");

        // Store granted in its third request cycle.
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, XW'(32'h100), XW'(32'hAB));
        tick(1'b0, "store_issue");
        exp_req = 1'b1; exp_addr = XW'(32'h100); exp_data = XW'(32'hAB);
        tick(1'b0, "store_wait1");
        tick(1'b0, "store_wait2");
        bus.mem_gnt = 1'b1;
        tick(1'b1, "store_gnt");
        bus.mem_gnt = 1'b0;
        idle();
        exp_req = 1'b0;
        tick(1'b0, "store_done");

        // Reset asserted while a store waits for its grant.
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, XW'(32'h200), XW'(32'hCD));
        tick(1'b0, "store2_issue");
        exp_req = 1'b1; exp_addr = XW'(32'h200); exp_data = XW'(32'hCD);
        tick(1'b0, "store2_wait");
        reset = 1'b0;
        #2;
        chk("async_rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("async_rst_ack", 64'(bus.ir_rob_ack), 64'd0);
`ifdef RETIRE_STATS_EN
        chk("async_rst_retired_cnt", 64'(retired_cnt), 64'd0);
        chk("async_rst_store_cnt", 64'(store_cnt), 64'd0);
`endif
        idle();
        #1;
        reset = 1'b1;
        exp_req = 1'b0;
        fl_q.delete(); amt_q.delete(); sq_q.delete();
        n_acks = 0; n_stores = 0;
        tick(1'b0, "post_reset");
        alu(14, 15, 11); tick(1'b1, "post_reset_alu");
        idle();          tick(1'b0, "post_reset_drain");

        // Halt, then nothing is ever acked or requested again.
        drive(1'b1, 1'b1, 20, 1'b1, 21, 9, 1'b0, 1'b1, 1'b0, '0, '0);
        tick(1'b1, "halt");
        alu(22, 23, 10);
        tick(1'b0, "halted0");
        tick(1'b0, "halted1");
        drive(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, XW'(32'h300), XW'(32'h1));
        tick(1'b0, "halted_store");
        tick(1'b0, "halted_store2");

`ifdef RETIRE_STATS_EN
        chk("retired_cnt", 64'(retired_cnt), 64'(n_acks));
        chk("store_cnt", 64'(store_cnt), 64'(n_stores));
`endif
        chk("fl_q_drained", 64'(fl_q.size()), 64'd0);
        chk("amt_q_drained", 64'(amt_q.size()), 64'd0);
        chk("sq_q_drained", 64'(sq_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/retire_stage.md
RETIRE_STAGE -- requirements
Module: retire_stage

Interface
REQ-001 Parameter XLEN_W, default `XLEN, width of PC, address and data fields.
REQ-002 Parameter STAT_W, default 32, width of statistics counters.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  asynchronous, active-low reset; state clears immediately when reset is low.
REQ-005 rob_ir_packet  input  ROB_IR_PACKET  ROB head view: retire_en, retire_t, retire_t_old, halt, wr_mem, dest_reg_idx, NPC, result, rs2_value, take_branch.
REQ-006 ir_rob_ack  output  1  head consumed this cycle; the ROB pops its head only when this is high.
REQ-007 ir_fl_packet  output  IR_FL_PACKET  free_en, free_t (retire_t_old) to the free list.
REQ-008 ir_amt_packet  output  IR_AMT_PACKET  write_en, dest_reg_idx, t (retire_t) to the architectural map table.
REQ-009 mem_req / mem_addr / mem_data  output  1 / XLEN_W / XLEN_W  store commit request, address, data.
REQ-010 mem_gnt  input  1  memory accepted the current store request.
REQ-011 squash_en / squash_pc  output  1 / XLEN_W  pipeline flush and redirect target.
REQ-012 halted  output  1  the processor has retired a halt instruction.

Function
REQ-013 FSM states: RUN, STORE_WAIT, SQUASH, HALTED.
REQ-014 RUN, retire_en=1, wr_mem=0, halt=0: ir_rob_ack=1 combinationally in the same cycle.
REQ-015 One cycle after any ack: ir_fl_packet.free_en=1 when retire_t_old.valid; ir_amt_packet.write_en=1 when retire_t.valid and dest_reg_idx!=0; both held for exactly one cycle.
REQ-016 RUN, retire_en=1, wr_mem=1: no ack; next cycle enter STORE_WAIT with mem_req=1, mem_addr=result, mem_data=rs2_value registered.
REQ-017 STORE_WAIT: mem_req, mem_addr and mem_data are held stable until mem_gnt=1; in the mem_gnt cycle ir_rob_ack=1, and mem_req drops the next cycle with return to RUN.
REQ-018 Acked head with take_branch=1: next state SQUASH; squash_en=1 for one cycle with squash_pc=result; no ack in SQUASH; then RUN.
REQ-019 Store with take_branch is not legal; stores never set take_branch.
REQ-020 Acked head with halt=1: next state HALTED; halted=1 persists; ir_rob_ack=0 and mem_req=0 forever until reset.
REQ-021 The stage retires at most one instruction per cycle; ir_rob_ack is never high while retire_en=0.
REQ-022 Back-to-back completed non-store heads retire on consecutive cycles with no bubbles.
REQ-023 retire_en dropping while in STORE_WAIT is illegal; the request is held regardless.

Reset
REQ-024 On reset low: state=RUN; ir_rob_ack, free_en, write_en, mem_req, squash_en and halted are 0; mem_addr, mem_data and squash_pc are 0; counters are 0.
REQ-025 Reset asserted mid-STORE_WAIT drops mem_req immediately; the store is abandoned and not acked.

Configuration
REQ-026 Macro RETIRE_STATS_EN: when defined, add outputs retired_cnt and store_cnt (STAT_W each); retired_cnt increments on every ack and store_cnt on every store ack; both saturate at all-ones and clear on reset.
REQ-027 Without RETIRE_STATS_EN, neither port nor counter exists and behaviour is otherwise identical.

Structure
REQ-028 IR_FL_PACKET, IR_AMT_PACKET and the retire FSM state enum belong in the shared sys_defs package next to ROB_IR_PACKET and TAG.
REQ-029 Optional sub-module retire_store_port holds the STORE_WAIT request/grant register logic; everything else stays flat.

Verification
REQ-030 Three completed ALU heads (t=5/6/7, t_old=1/2/3, dest 4/5/6) -> ack on cycles 0, 1, 2; free_t 1, 2, 3 and AMT writes on cycles 1, 2, 3.
REQ-031 Store head (result=0x100, rs2_value=0xAB), mem_gnt after 3 cycles -> mem_req stable 3 cycles at 0x100/0xAB, one ack in the gnt cycle, mem_req low next cycle.
REQ-032 Branch head with take_branch=1 and result=0x40 -> ack, then squash_en=1 with squash_pc=0x40 one cycle, no ack that cycle, next completed head acked after.
REQ-033 Halt head followed by a completed head -> halt acked, halted=1 from the next cycle, second head never acked.
REQ-034 Reset pulled low during STORE_WAIT -> mem_req 0 without a clock edge; after release state RUN and counters 0.
REQ-035 dest_reg_idx=0 with valid t -> free list is still updated; the AMT write is suppressed.
